m6809_bus_arbiter: RTL and testbench
====================================

# m6809_bus_arbiter

Two-master arbiter that shares the single memory port (ROM/RAM decode and muxing downstream) between the 6809 core and a DMA/loader master. It sits between the core's address/data bus and the memory decode in the integration layer. The CPU owns the bus by default. A DMA master obtains it through a req/gnt handshake, and the CPU is stalled while the DMA master owns it. A burst limit with a CPU guard window prevents the DMA master from starving the core.

## Interface
- ADDR_W, 16, address width
- DATA_W, 8, data width
- MAX_BURST, 8, DMA accesses per grant before forced release (1..255)
- CPU_SLOTS, 1, guard cycles given to the CPU after a forced release (1..255)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access valid this cycle
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rw_n  in  1  CPU access type: 1 = read, 0 = write
- cpu_rdata  out  DATA_W  read data to the CPU
- cpu_stall  out  1  CPU must hold its current access
- dma_req  in  1  DMA access request; held high for the whole burst
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_rw_n  in  1  DMA access type: 1 = read, 0 = write
- dma_gnt  out  1  DMA owns the bus
- dma_ack  out  1  DMA access completes this cycle
- dma_rdata  out  DATA_W  read data to the DMA master
- mem_valid  out  1  memory access this cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rw_n  out  1  memory access type: 1 = read, 0 = write
- mem_rdata  in  DATA_W  memory read data; combinational, valid in the same cycle

## Operation
- States:
  - CPU_OWN (reset state)
  - DMA_OWN
  - CPU_GUARD
- Owner mux:
  - In DMA_OWN, the mem_* outputs come from dma_*.
  - Otherwise, the mem_* outputs come from cpu_*.
  - mem_valid = cpu_req when the CPU owns the bus; mem_valid = dma_req in DMA_OWN.
- cpu_rdata and dma_rdata both equal mem_rdata at all times. Each master qualifies the data with its own ownership.
- CPU_OWN:
  - If dma_req = 1, go to DMA_OWN and clear burst_cnt. The CPU access in this cycle, if any, completes.
- DMA_OWN:
  - dma_gnt = 1 and cpu_stall = 1.
  - dma_ack = dma_req (combinational).
  - Each acked access increments burst_cnt (8-bit).
  - If dma_req = 0, go to CPU_OWN.
  - Else if the acked access is number MAX_BURST, go to CPU_GUARD and load guard_cnt with CPU_SLOTS.
- CPU_GUARD:
  - The CPU owns the bus and dma_req is ignored.
  - guard_cnt decrements each cycle. On the cycle it reaches 1, go to CPU_OWN.
- A DMA master that drops dma_req and re-raises it restarts burst_cnt at 0. This is permitted behaviour.
- A write commits at the memory on the clk edge that ends a cycle with mem_valid = 1 and mem_rw_n = 0. The arbiter never issues two accesses in one cycle.

## Timing
- Reset values (asynchronous):
  - state = CPU_OWN, burst_cnt = 0, guard_cnt = 0
  - dma_gnt = 0, cpu_stall = 0, dma_ack = 0
  - mem_* outputs follow cpu_*; mem_valid = cpu_req.
- dma_gnt and cpu_stall are registered and decoded from state. dma_ack, the mem_* outputs and the rdata outputs are combinational.
- Grant latency: dma_req sampled high at edge k gives dma_gnt = 1 from edge k until the release edge.
- Release: dma_req sampled low in DMA_OWN gives dma_gnt = 0 and cpu_stall = 0 in the next cycle.
- Sustained dma_req produces a periodic pattern:
  - MAX_BURST granted cycles,
  - then CPU_SLOTS guard cycles,
  - then 1 CPU_OWN cycle,
  - then a re-grant.
- Simultaneous cpu_req and dma_req in CPU_OWN: the CPU wins that cycle and the DMA master is granted on the next cycle.
- Reset asserted mid-burst: dma_gnt and cpu_stall drop immediately (asynchronously). Any in-flight DMA write is not committed.

## Test plan
- Reset, then a CPU read at 0x0010 with mem_rdata = 0x3C -> mem_addr = 0x0010, mem_valid = 1, cpu_rdata = 0x3C, dma_gnt = 0, cpu_stall = 0.
- dma_req with a write of 0xA5 to 0x0020 for one access -> dma_gnt and cpu_stall high on the next cycle, dma_ack = 1 that cycle, mem write of 0xA5 to 0x0020. Drop dma_req -> CPU_OWN on the next cycle with stall low.
- MAX_BURST = 8, CPU_SLOTS = 1, dma_req held for 30 cycles -> repeating pattern of 8 acks followed by 2 cycles with gnt = 0. CPU accesses pass through in those 2 cycles.
- cpu_req and dma_req asserted in the same CPU_OWN cycle -> CPU read completes with mem_addr = cpu_addr; gnt rises on the next cycle.
- Reset pulsed on the 3rd access of a DMA burst -> dma_gnt, dma_ack and cpu_stall are 0 immediately; state is CPU_OWN and burst_cnt = 0 after reset is released.
- dma_req toggled low for 1 cycle after 5 accesses -> CPU gets 1 cycle; the re-grant restarts the count, so 8 further acks occur before the guard window.

Source files
------------

// File: rtl/m6809_bus_arbiter_if.sv
// CPU, DMA and memory-side signals of the shared 6809 memory port.
// The master modport is the integration side; the slave modport is the arbiter.
interface m6809_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw_n;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_rw_n;
    logic              dma_gnt;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rw_n;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_rw_n,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_addr, dma_wdata, dma_rw_n,
        input  dma_gnt, dma_ack, dma_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_rw_n,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_rw_n,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_addr, dma_wdata, dma_rw_n,
        output dma_gnt, dma_ack, dma_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_rw_n,
        input  mem_rdata
    );
endinterface

// File: rtl/m6809_bus_arbiter.sv
// Shares one memory port between the 6809 core (default owner) and a DMA master.
// Grant/stall registered from state, mux and ack combinational; burst limit plus guard window.
module m6809_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8,
    parameter int CPU_SLOTS = 1
) (
    input  logic                clk,
    input  logic                reset,
    m6809_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        DMA_OWN   = 2'd1,
        CPU_GUARD = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] GUARD_LD  = 8'(CPU_SLOTS);

    state_t      state, state_nxt;
    logic [7:0]  burst_cnt, burst_nxt;
    logic [7:0]  guard_cnt, guard_nxt;
    logic        dma_own;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CPU_OWN;
            burst_cnt <= 8'd0;
            guard_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            guard_cnt <= guard_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        guard_nxt = guard_cnt;
        case (state)
            CPU_OWN: begin
                // Any CPU access this cycle still completes; DMA takes over next cycle.
                if (bus.dma_req) begin
                    state_nxt = DMA_OWN;
                    burst_nxt = 8'd0;
                end
            end
            DMA_OWN: begin
                if (!bus.dma_req) begin
                    state_nxt = CPU_OWN;
                end else begin
                    burst_nxt = burst_cnt + 8'd1;
                    if (burst_nxt == BURST_LIM) begin
                        state_nxt = CPU_GUARD;
                        guard_nxt = GUARD_LD;
                    end
                end
            end
            CPU_GUARD: begin
                guard_nxt = guard_cnt - 8'd1;
                if (guard_cnt <= 8'd1) begin
                    state_nxt = CPU_OWN;
                end
            end
            default: begin
                state_nxt = CPU_OWN;
            end
        endcase
    end

    assign dma_own       = (state == DMA_OWN);
    assign bus.dma_gnt   = dma_own;
    assign bus.cpu_stall = dma_own;
    assign bus.dma_ack   = dma_own & bus.dma_req;

    assign addr_sel      = dma_own ? bus.dma_addr  : bus.cpu_addr;
    assign wdata_sel     = dma_own ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.mem_valid = dma_own ? bus.dma_req   : bus.cpu_req;
    assign bus.mem_rw_n  = dma_own ? bus.dma_rw_n  : bus.cpu_rw_n;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;

    // Both masters see the memory data; each qualifies it with its own ownership.
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Directed bench for m6809_bus_arbiter: reset, CPU/DMA accesses, burst/guard cadence,
// mid-burst reset and burst restart after a dropped request.
module tb_m6809_bus_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    m6809_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    m6809_bus_arbiter #(
        .ADDR_W(16), .DATA_W(8), .MAX_BURST(8), .CPU_SLOTS(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.cpu_req   = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00; bus.cpu_rw_n = 1'b1;
        bus.dma_req   = 1'b1; bus.dma_addr = 16'h0000; bus.dma_wdata = 8'h00; bus.dma_rw_n = 1'b1;
        bus.mem_rdata = 8'h00;
        tick(); tick();
        #1;
        chk("rst_gnt",   32'(bus.dma_gnt),   32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_ack",   32'(bus.dma_ack),   32'd0);
        chk("rst_valid", 32'(bus.mem_valid), 32'd0);

        // CPU read
        bus.dma_req = 1'b0;
        reset = 1'b0;
        tick();
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_rw_n = 1'b1; bus.mem_rdata = 8'h3C;
        #1;
        chk("cpu_rd_addr",  32'(bus.mem_addr),  32'h0010);
        chk("cpu_rd_valid", 32'(bus.mem_valid), 32'd1);
        chk("cpu_rd_data",  32'(bus.cpu_rdata), 32'h3C);
        chk("cpu_rd_gnt",   32'(bus.dma_gnt),   32'd0);
        chk("cpu_rd_stall", 32'(bus.cpu_stall), 32'd0);

        // Single DMA write
        tick();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b1; bus.dma_addr = 16'h0020; bus.dma_wdata = 8'hA5; bus.dma_rw_n = 1'b0;
        #1;
        chk("dmaw_req_gnt", 32'(bus.dma_gnt), 32'd0);
        chk("dmaw_req_ack", 32'(bus.dma_ack), 32'd0);
        tick();
        chk("dmaw_gnt",   32'(bus.dma_gnt),   32'd1);
        chk("dmaw_stall", 32'(bus.cpu_stall), 32'd1);
        chk("dmaw_ack",   32'(bus.dma_ack),   32'd1);
        chk("dmaw_valid", 32'(bus.mem_valid), 32'd1);
        chk("dmaw_addr",  32'(bus.mem_addr),  32'h0020);
        chk("dmaw_wdata", 32'(bus.mem_wdata), 32'hA5);
        chk("dmaw_rw_n",  32'(bus.mem_rw_n),  32'd0);
        tick();
        bus.dma_req = 1'b0;
        #1;
        chk("dmaw_drop_gnt",   32'(bus.dma_gnt),   32'd1);
        chk("dmaw_drop_ack",   32'(bus.dma_ack),   32'd0);
        chk("dmaw_drop_valid", 32'(bus.mem_valid), 32'd0);
        tick();
        chk("dmaw_rel_gnt",   32'(bus.dma_gnt),   32'd0);
        chk("dmaw_rel_stall", 32'(bus.cpu_stall), 32'd0);

        // Simultaneous requests: CPU wins this cycle
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_rw_n = 1'b1;
        bus.dma_req = 1'b1; bus.dma_addr = 16'h0100; bus.dma_rw_n = 1'b1;
        #1;
        chk("sim_addr",  32'(bus.mem_addr),  32'h0200);
        chk("sim_valid", 32'(bus.mem_valid), 32'd1);
        chk("sim_gnt",   32'(bus.dma_gnt),   32'd0);

        // Sustained request: 8 granted, 1 guard, 1 CPU_OWN, repeat
        for (int i = 0; i < 30; i++) begin
            tick();
            chk($sformatf("sus_gnt_%0d", i), 32'(bus.dma_gnt), ((i % 10) < 8) ? 32'd1 : 32'd0);
            chk($sformatf("sus_ack_%0d", i), 32'(bus.dma_ack), ((i % 10) < 8) ? 32'd1 : 32'd0);
            chk($sformatf("sus_addr_%0d", i), 32'(bus.mem_addr),
                ((i % 10) < 8) ? 32'h0100 : 32'h0200);
            chk($sformatf("sus_valid_%0d", i), 32'(bus.mem_valid), 32'd1);
        end

        // Reset on the 3rd access of a DMA write burst
        bus.cpu_req = 1'b0;
        bus.dma_addr = 16'h0300; bus.dma_wdata = 8'h77; bus.dma_rw_n = 1'b0;
        tick(); tick(); tick();
        chk("rb_pre_ack", 32'(bus.dma_ack), 32'd1);
        reset = 1'b1;
        #1;
        chk("rb_gnt",   32'(bus.dma_gnt),   32'd0);
        chk("rb_ack",   32'(bus.dma_ack),   32'd0);
        chk("rb_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rb_valid", 32'(bus.mem_valid), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rb_rel_gnt", 32'(bus.dma_gnt), 32'd0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk($sformatf("rb_burst_gnt_%0d", j), 32'(bus.dma_gnt), (j < 8) ? 32'd1 : 32'd0);
        end

        // Drop request after 5 accesses; re-grant restarts the burst count
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0400; bus.cpu_rw_n = 1'b1;
        bus.dma_rw_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("tg_ack_%0d", k), 32'(bus.dma_ack), 32'd1);
        end
        tick();
        bus.dma_req = 1'b0;
        #1;
        chk("tg_low_gnt", 32'(bus.dma_gnt), 32'd1);
        chk("tg_low_ack", 32'(bus.dma_ack), 32'd0);
        tick();
        bus.dma_req = 1'b1;
        #1;
        chk("tg_cpu_gnt",   32'(bus.dma_gnt),   32'd0);
        chk("tg_cpu_addr",  32'(bus.mem_addr),  32'h0400);
        chk("tg_cpu_valid", 32'(bus.mem_valid), 32'd1);
        for (int m = 0; m < 10; m++) begin
            tick();
            chk($sformatf("tg_re_ack_%0d", m), 32'(bus.dma_ack), (m < 8) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
